// File: rtl/multicycle_control_fsm.sv
// Moore control unit for a multicycle load/store datapath. Strobes and selects are
// registered from the next state, so an asynchronous reset presents FETCH values at once.
module multicycle_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] cond,
   input  logic       alu_zero,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] alu_control,
   output logic [1:0] imm_src,
   output logic       flag_zero,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] alu_control;
   } ctrl_t;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   function automatic logic cmd_defined(input logic [3:0] cmd);
      logic ok;
      case (cmd)
         CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR: ok = 1'b1;
         default:                                    ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
      logic [1:0] ctl;
      case (cmd)
         CMD_ADD: ctl = 2'b00;
         CMD_SUB: ctl = 2'b01;
         CMD_AND: ctl = 2'b10;
         CMD_ORR: ctl = 2'b11;
         CMD_CMP: ctl = 2'b01;
         default: ctl = 2'b00;
      endcase
      return ctl;
   endfunction

   function automatic logic cond_pass(input logic [3:0] c, input logic z);
      logic pass;
      case (c)
         4'b0000: pass = z;
         4'b0001: pass = ~z;
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

   function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] cmd);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.pc_write   = 1'b1;
            c.alu_src_a  = 2'b10;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_DECODE: begin
            c.alu_src_a  = 2'b10;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_MEMADR:   c.alu_src_b = 2'b01;
         S_MEMREAD:  c.adr_src   = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECR:    c.alu_control = alu_decode(cmd);
         S_EXECI: begin
            c.alu_src_b   = 2'b01;
            c.alu_control = alu_decode(cmd);
         end
         S_ALUWB:    c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.pc_write   = 1'b1;
         end
         default:    c = '0;
      endcase
      return c;
   endfunction

   state_t     r_state;
   state_t     w_next;
   ctrl_t      r_ctrl;
   logic       r_flag_zero;
   logic [3:0] w_cmd;
   logic       w_exec;
   logic       w_flag_load;

   assign w_cmd       = funct[4:1];
   assign w_exec      = (r_state == S_EXECR) || (r_state == S_EXECI);
   assign w_flag_load = w_exec && (funct[0] || (w_cmd == CMD_CMP));

   // Next-state selection; a failed condition or undefined instruction is nullified in DECODE
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (!cond_pass(cond, r_flag_zero) || (op == 2'b11) ||
                ((op == 2'b00) && !cmd_defined(w_cmd))) begin
               w_next = S_FETCH;
            end else begin
               case (op)
                  2'b01:   w_next = S_MEMADR;
                  2'b00:   w_next = funct[5] ? S_EXECI : S_EXECR;
                  2'b10:   w_next = S_BRANCH;
                  default: w_next = S_FETCH;
               endcase
            end
         end
         S_MEMADR:  w_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: w_next = S_MEMWB;
         S_EXECR, S_EXECI: begin
            if (w_cmd == CMD_CMP) begin
               w_next = S_FETCH;
            end else begin
               w_next = S_ALUWB;
            end
         end
         default:   w_next = S_FETCH;
      endcase
   end

   // State, registered control word and stored zero flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_ctrl      <= ctrl_for(S_FETCH, 4'd0);
         r_flag_zero <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= ctrl_for(w_next, w_cmd);
         if (w_flag_load) begin
            r_flag_zero <= alu_zero;
         end
      end
   end

   assign pc_write    = r_ctrl.pc_write;
   assign ir_write    = r_ctrl.ir_write;
   assign reg_write   = r_ctrl.reg_write;
   assign mem_write   = r_ctrl.mem_write;
   assign adr_src     = r_ctrl.adr_src;
   assign alu_src_a   = r_ctrl.alu_src_a;
   assign alu_src_b   = r_ctrl.alu_src_b;
   assign result_src  = r_ctrl.result_src;
   assign alu_control = r_ctrl.alu_control;
   assign imm_src     = op;
   assign flag_zero   = r_flag_zero;
   assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction table, async-reset corner
// sequence and randomized instructions against a path-level reference model.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cond;
   logic       alu_zero;
   logic       pc_write, ir_write, reg_write, mem_write, adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src, alu_control, imm_src;
   logic       flag_zero;
   logic [3:0] state;

   int checks = 0;
   int failures = 0;
   logic m_flag = 1'b0;
   logic [10:0] tbl [10];

   typedef struct {
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] cond;
      logic       aluz;
      int         exp_len;
      logic       exp_flag;
   } vec_t;

   vec_t vecs [14];

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .cond(cond), .alu_zero(alu_zero),
      .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
      .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .result_src(result_src), .alu_control(alu_control), .imm_src(imm_src),
      .flag_zero(flag_zero), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] outs_now();
      return {pc_write, ir_write, reg_write, mem_write, adr_src,
              alu_src_a, alu_src_b, result_src, alu_control, imm_src};
   endfunction

   function automatic logic [1:0] alu_ref(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return 2'b00;
         4'b0010: return 2'b01;
         4'b0000: return 2'b10;
         4'b1100: return 2'b11;
         4'b1010: return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Runs one instruction from FETCH until the DUT returns to FETCH; returns its measured length
   task automatic exec_instr(input logic [1:0] i_op, input logic [5:0] i_f,
                             input logic [3:0] i_c, input logic i_z, output int n_cyc);
      int p[$];
      int s;
      logic pass, def, upd;
      logic [3:0] cmd;
      op = i_op; funct = i_f; cond = i_c; alu_zero = i_z;
      cmd  = i_f[4:1];
      pass = (i_c == 4'he) || (i_c == 4'h0 && m_flag) || (i_c == 4'h1 && !m_flag);
      def  = (cmd == 4'd0) || (cmd == 4'd2) || (cmd == 4'd4) || (cmd == 4'd10) || (cmd == 4'd12);
      p = {0, 1};
      if (pass && i_op != 2'b11 && !(i_op == 2'b00 && !def)) begin
         if (i_op == 2'b01) begin
            p.push_back(2);
            if (i_f[0]) begin p.push_back(3); p.push_back(4); end
            else p.push_back(5);
         end else if (i_op == 2'b10) begin
            p.push_back(9);
         end else begin
            p.push_back(i_f[5] ? 7 : 6);
            if (cmd != 4'b1010) p.push_back(8);
         end
      end
      n_cyc = 0;
      do begin
         upd = 1'b0;
         if (n_cyc < p.size()) begin
            s = p[n_cyc];
            chk("state", {28'd0, state}, s);
            chk("outputs", {17'd0, outs_now()},
                {17'd0, tbl[s], ((s == 6 || s == 7) ? alu_ref(cmd) : 2'b00), i_op});
            upd = (s == 6 || s == 7) && (i_f[0] || cmd == 4'b1010);
         end else begin
            chk("overrun_state", {28'd0, state}, 32'd0);
         end
         chk("flag_zero", {31'd0, flag_zero}, {31'd0, m_flag});
         @(posedge clk);
         @(negedge clk);
         if (upd) m_flag = i_z;
         n_cyc++;
      end while (state != 4'd0 && n_cyc < 8);
      chk("latency", n_cyc, p.size());
   endtask

   initial begin
      int n;
      tbl[0] = 11'b11000_10_10_10;
      tbl[1] = 11'b00000_10_10_10;
      tbl[2] = 11'b00000_00_01_00;
      tbl[3] = 11'b00001_00_00_00;
      tbl[4] = 11'b00100_00_00_01;
      tbl[5] = 11'b00011_00_00_00;
      tbl[6] = 11'b00000_00_00_00;
      tbl[7] = 11'b00000_00_01_00;
      tbl[8] = 11'b00100_00_00_00;
      tbl[9] = 11'b10000_00_01_10;

      vecs[0]  = '{2'b01, 6'b0_0000_1, 4'he, 1'b0, 5, 1'b0};
      vecs[1]  = '{2'b01, 6'b0_0000_0, 4'he, 1'b0, 4, 1'b0};
      vecs[2]  = '{2'b00, 6'b0_0010_1, 4'he, 1'b1, 4, 1'b1};
      vecs[3]  = '{2'b10, 6'b0_0000_0, 4'h1, 1'b0, 2, 1'b1};
      vecs[4]  = '{2'b10, 6'b0_0000_0, 4'h0, 1'b0, 3, 1'b1};
      vecs[5]  = '{2'b00, 6'b0_1010_0, 4'he, 1'b0, 3, 1'b0};
      vecs[6]  = '{2'b11, 6'b0_0100_1, 4'he, 1'b1, 2, 1'b0};
      vecs[7]  = '{2'b00, 6'b1_1111_1, 4'he, 1'b1, 2, 1'b0};
      vecs[8]  = '{2'b00, 6'b1_0100_0, 4'he, 1'b1, 4, 1'b0};
      vecs[9]  = '{2'b00, 6'b1_1100_1, 4'he, 1'b1, 4, 1'b1};
      vecs[10] = '{2'b01, 6'b0_0000_1, 4'h0, 1'b0, 5, 1'b1};
      vecs[11] = '{2'b00, 6'b0_0100_1, 4'h5, 1'b0, 2, 1'b1};
      vecs[12] = '{2'b00, 6'b0_0000_1, 4'he, 1'b0, 4, 1'b0};
      vecs[13] = '{2'b10, 6'b0_0000_0, 4'h0, 1'b0, 2, 1'b0};

      reset = 1'b1; op = 2'b11; funct = 6'd0; cond = 4'd0; alu_zero = 1'b0;
      #1;
      chk("reset_state", {28'd0, state}, 32'd0);
      chk("reset_flag", {31'd0, flag_zero}, 32'd0);
      chk("reset_outputs", {17'd0, outs_now()}, {17'd0, tbl[0], 2'b00, 2'b11});
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         exec_instr(vecs[i].op, vecs[i].funct, vecs[i].cond, vecs[i].aluz, n);
         chk($sformatf("vec%0d_len", i), n, vecs[i].exp_len);
         chk($sformatf("vec%0d_flag", i), {31'd0, flag_zero}, {31'd0, vecs[i].exp_flag});
      end

      // Set the flag, then reset asynchronously in the middle of a store
      exec_instr(2'b00, 6'b1_1100_1, 4'he, 1'b1, n);
      op = 2'b01; funct = 6'b0_0000_0; cond = 4'he;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("mw_state", {28'd0, state}, 32'd5);
      chk("mw_strobe", {31'd0, mem_write}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mw_strobe", {31'd0, mem_write}, 32'd0);
      chk("rst_mw_state", {28'd0, state}, 32'd0);
      chk("rst_mw_flag", {31'd0, flag_zero}, 32'd0);
      chk("rst_mw_outputs", {17'd0, outs_now()}, {17'd0, tbl[0], 2'b00, 2'b01});
      @(negedge clk);
      chk("rst_hold_state", {28'd0, state}, 32'd0);
      chk("rst_hold_writes", {30'd0, reg_write, mem_write}, 32'd0);
      reset = 1'b0;
      m_flag = 1'b0;
      exec_instr(2'b11, 6'd0, 4'he, 1'b1, n);

      for (int r = 0; r < 200; r++) begin
         logic [3:0] c;
         case ($urandom_range(0, 3))
            0:       c = 4'h0;
            1:       c = 4'h1;
            2:       c = 4'he;
            default: c = 4'($urandom_range(0, 15));
         endcase
         exec_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), c,
                    1'($urandom_range(0, 1)), n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
